// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared definitions for the frequency meter.
// Holds the FSM state encoding, the default gate length and a helper that
// sizes the gate timer.
package freq_meter_pkg;

   // state      | meaning
   // -----------+--------------------------------------------------------
   // ST_IDLE    | no gate open, waiting for start or continuous mode
   // ST_MEASURE | gate open, counting rising edges of the synchronised input
   // ST_DONE    | single cycle: result published on freq, valid high
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // One second at 50 MHz.
   localparam int GATE_CYCLES_DEF = 50_000_000;

   // Gate timer width; a one-cycle gate still needs a one-bit counter.
   function automatic int timer_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/freq_meter_gate_timer.sv
// gate_timer: counts clock cycles while the measurement gate is open and
// flags the final cycle of the gate. The counter is held at zero whenever
// clear is high so the next gate always starts from cycle 0.
module gate_timer
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
   input  logic clk_50MHz,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic last
);

   localparam int TW = timer_width(GATE_CYCLES);
   localparam logic [TW-1:0] LAST_CNT = TW'(GATE_CYCLES - 1);

   logic [TW-1:0] gate_cnt;

   // Gate cycle counter: cleared outside the gate, advances once per gate cycle.
   always_ff @(posedge clk_50MHz) begin
      if (rst || clear) begin
         gate_cnt <= '0;
      end else if (en) begin
         gate_cnt <= gate_cnt + 1'b1;
      end
   end

   // Full-width terminal compare, qualified by the gate being open.
   assign last = en && (gate_cnt == LAST_CNT);

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed gate
// of GATE_CYCLES clocks and publishes the count on freq with a valid pulse.
// Single-shot on start, or free-running while cont is high.
// Optional build macro FREQ_METER_OVF_EN adds an ovf output reporting that
// edges were lost to counter saturation during the last gate.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = GATE_CYCLES_DEF,
   parameter int CNT_W       = 32
) (
   input  logic             clk_50MHz,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   input  logic             cont,
   output logic [CNT_W-1:0] freq,
   output logic             valid,
   output logic             busy
`ifdef FREQ_METER_OVF_EN
   ,
   output logic             ovf
`endif
);

   state_t           state;
   state_t           state_nxt;

   logic             sig_sync1;
   logic             sig_sync2;
   logic             sig_prev;
   logic             edge_det;

   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] edge_cnt_inc;
   logic             edge_cnt_full;

   logic             gate_open;
   logic             gate_last;

   // Two-flop synchroniser followed by a history flop for edge detection.
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         sig_sync1 <= 1'b0;
         sig_sync2 <= 1'b0;
         sig_prev  <= 1'b0;
      end else begin
         sig_sync1 <= sig_in;
         sig_sync2 <= sig_sync1;
         sig_prev  <= sig_sync2;
      end
   end

   assign edge_det = sig_sync2 & ~sig_prev;

   // State register.
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start is only honoured from IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start || cont) begin
               state_nxt = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (gate_last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = cont ? ST_MEASURE : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign gate_open = (state == ST_MEASURE);
   assign busy      = gate_open;
   assign valid     = (state == ST_DONE);

   // Timer is cleared in IDLE and DONE so every gate starts at cycle 0.
   gate_timer #(
      .GATE_CYCLES (GATE_CYCLES)
   ) u_gate_timer (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .clear     (~gate_open),
      .en        (gate_open),
      .last      (gate_last)
   );

   // Saturating increment; the same value feeds the counter and the result
   // so an edge in the final gate cycle is included in freq.
   assign edge_cnt_full = &edge_cnt;
   assign edge_cnt_inc  = (edge_det && !edge_cnt_full) ? edge_cnt + 1'b1 : edge_cnt;

   // Edge counter: only runs inside the gate, zero otherwise.
   always_ff @(posedge clk_50MHz) begin
      if (rst || !gate_open) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= edge_cnt_inc;
      end
   end

   // Result register: loaded on the last gate cycle, held until the next one.
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         freq <= '0;
      end else if (gate_last) begin
         freq <= edge_cnt_inc;
      end
   end

`ifdef FREQ_METER_OVF_EN
   logic edge_lost;
   logic edge_lost_now;

   // An edge arriving while the counter already holds all-ones is dropped.
   assign edge_lost_now = edge_det && edge_cnt_full;

   // Sticky per-gate record of dropped edges.
   always_ff @(posedge clk_50MHz) begin
      if (rst || !gate_open) begin
         edge_lost <= 1'b0;
      end else if (edge_lost_now) begin
         edge_lost <= 1'b1;
      end
   end

   // Overflow flag published alongside freq.
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (gate_last) begin
         ovf <= edge_lost | edge_lost_now;
      end
   end
`endif

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
// tb_freq_meter: directed bench for freq_meter with a 1000-cycle gate and a
// second 4-bit / 100-cycle instance for saturation.
module tb_freq_meter;

   logic        clk_50MHz = 1'b0;
   logic        rst       = 1'b1;
   logic        start     = 1'b0;
   logic        cont      = 1'b0;
   logic        start2    = 1'b0;
   logic        sig_man   = 1'b0;
   logic        sq_en     = 1'b0;
   logic        sq_wave   = 1'b0;
   logic        sq2       = 1'b0;
   logic        sig_in;
   logic [31:0] freq;
   logic        valid;
   logic        busy;
   logic [3:0]  freq2;
   logic        valid2;
   logic        busy2;
`ifdef FREQ_METER_OVF_EN
   logic        ovf;
   logic        ovf2;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #10 clk_50MHz = ~clk_50MHz;
   // 50-cycle period square wave, edges away from clock edges.
   always #500 sq_wave = ~sq_wave;
   // 2-cycle period square wave for the saturation instance.
   always #20 sq2 = ~sq2;

   assign sig_in = sq_en ? sq_wave : sig_man;

   freq_meter #(
      .GATE_CYCLES (1000),
      .CNT_W       (32)
   ) u_dut (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .sig_in    (sig_in),
      .start     (start),
      .cont      (cont),
      .freq      (freq),
      .valid     (valid),
      .busy      (busy)
`ifdef FREQ_METER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   freq_meter #(
      .GATE_CYCLES (100),
      .CNT_W       (4)
   ) u_dut_sat (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .sig_in    (sq2),
      .start     (start2),
      .cont      (1'b0),
      .freq      (freq2),
      .valid     (valid2),
      .busy      (busy2)
`ifdef FREQ_METER_OVF_EN
      ,
      .ovf       (ovf2)
`endif
   );

   task automatic tick();
      @(posedge clk_50MHz);
      #1;
   endtask

   // Pulses start and counts ticks until valid; n = budget+1 on timeout.
   task automatic start_and_wait(input int budget, output int n);
      start = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         start = 1'b0;
      end while (valid !== 1'b1 && n <= budget);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (freq !== 32'd0) begin n_bad++; $display("FAIL reset_freq got %0d expected 0", freq); end
      n_cmp++;
      if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b expected 0", valid); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b expected 0", busy); end
`ifdef FREQ_METER_OVF_EN
      n_cmp++;
      if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b expected 0", ovf); end
`endif
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int n;
      sq_en = 1'b1;
      repeat (10) tick();
      start_and_wait(1100, n);
      n_cmp++;
      if (n !== 1001) begin n_bad++; $display("FAIL single_latency got %0d expected 1001", n); end
      n_cmp++;
      if (freq !== 32'd20) begin n_bad++; $display("FAIL single_freq got %0d expected 20", freq); end
`ifdef FREQ_METER_OVF_EN
      n_cmp++;
      if (ovf !== 1'b0) begin n_bad++; $display("FAIL single_ovf got %b expected 0", ovf); end
`endif
      tick();
      n_cmp++;
      if (valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_pulse got %b expected 0", valid); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after got %b expected 0", busy); end
   endtask

   task automatic test_cont();
      int last_t    = -1;
      int pulses    = 0;
      int bad_iv    = 0;
      int bad_freq  = 0;
      int bad_busy  = 0;
      int n;
      cont = 1'b1;
      for (int t = 1; t <= 4000; t++) begin
         tick();
         if (busy === valid) bad_busy++;
         if (valid === 1'b1) begin
            pulses++;
            if (freq !== 32'd20) bad_freq++;
            if (last_t >= 0 && (t - last_t) != 1001) bad_iv++;
            last_t = t;
         end
      end
      n_cmp++;
      if (pulses !== 3) begin n_bad++; $display("FAIL cont_pulses got %0d expected 3", pulses); end
      n_cmp++;
      if (bad_iv !== 0) begin n_bad++; $display("FAIL cont_interval bad intervals %0d expected 0", bad_iv); end
      n_cmp++;
      if (bad_freq !== 0) begin n_bad++; $display("FAIL cont_freq bad results %0d expected 0", bad_freq); end
      n_cmp++;
      if (bad_busy !== 0) begin n_bad++; $display("FAIL cont_busy bad cycles %0d expected 0", bad_busy); end
      cont = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (valid !== 1'b1 && n <= 1100);
      n_cmp++;
      if (n !== 4) begin n_bad++; $display("FAIL cont_stop_latency got %0d expected 4", n); end
      repeat (3) tick();
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_stop_busy got %b expected 0", busy); end
   endtask

   task automatic test_edges();
      int n;
      sq_en   = 1'b0;
      sig_man = 1'b0;
      repeat (5) tick();
      start_and_wait(1100, n);
      n_cmp++;
      if (freq !== 32'd0) begin n_bad++; $display("FAIL zero_freq got %0d expected 0", freq); end
      repeat (3) tick();
      // Rising input edge timed so the detector fires in the last gate cycle.
      start = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         start = 1'b0;
         if (n == 998) sig_man = 1'b1;
      end while (valid !== 1'b1 && n <= 1100);
      n_cmp++;
      if (n !== 1001) begin n_bad++; $display("FAIL last_edge_latency got %0d expected 1001", n); end
      n_cmp++;
      if (freq !== 32'd1) begin n_bad++; $display("FAIL last_edge_freq got %0d expected 1", freq); end
      sig_man = 1'b0;
      repeat (5) tick();
      // One cycle later the detector fires during DONE and must be ignored.
      start = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         start = 1'b0;
         if (n == 999) sig_man = 1'b1;
      end while (valid !== 1'b1 && n <= 1100);
      n_cmp++;
      if (freq !== 32'd0) begin n_bad++; $display("FAIL done_edge_freq got %0d expected 0", freq); end
      sig_man = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_reset_mid();
      int n;
      int seen = 0;
      sq_en = 1'b1;
      repeat (5) tick();
      start_and_wait(1100, n);
      n_cmp++;
      if (freq !== 32'd20) begin n_bad++; $display("FAIL pre_reset_freq got %0d expected 20", freq); end
      tick();
      start = 1'b1;
      for (int i = 0; i < 500; i++) begin
         tick();
         start = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy got %b expected 0", busy); end
      n_cmp++;
      if (freq !== 32'd0) begin n_bad++; $display("FAIL mid_reset_freq got %0d expected 0", freq); end
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (valid === 1'b1) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin n_bad++; $display("FAIL mid_reset_valid got %0d pulses expected 0", seen); end
      start_and_wait(1100, n);
      n_cmp++;
      if (n !== 1001) begin n_bad++; $display("FAIL post_reset_latency got %0d expected 1001", n); end
      n_cmp++;
      if (freq !== 32'd20) begin n_bad++; $display("FAIL post_reset_freq got %0d expected 20", freq); end
      tick();
   endtask

   task automatic test_start_while_busy();
      int n;
      start = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         start = (n == 300) ? 1'b1 : 1'b0;
      end while (valid !== 1'b1 && n <= 1100);
      n_cmp++;
      if (n !== 1001) begin n_bad++; $display("FAIL busy_start_latency got %0d expected 1001", n); end
      n_cmp++;
      if (freq !== 32'd20) begin n_bad++; $display("FAIL busy_start_freq got %0d expected 20", freq); end
      // start during DONE is ignored as well.
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL done_start_busy got %b expected 0", busy); end
      n_cmp++;
      if (valid !== 1'b0) begin n_bad++; $display("FAIL done_start_valid got %b expected 0", valid); end
   endtask

   task automatic test_saturation();
      int n;
      start2 = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         start2 = 1'b0;
      end while (valid2 !== 1'b1 && n <= 200);
      n_cmp++;
      if (n !== 101) begin n_bad++; $display("FAIL sat_latency got %0d expected 101", n); end
      n_cmp++;
      if (freq2 !== 4'd15) begin n_bad++; $display("FAIL sat_freq got %0d expected 15", freq2); end
`ifdef FREQ_METER_OVF_EN
      n_cmp++;
      if (ovf2 !== 1'b1) begin n_bad++; $display("FAIL sat_ovf got %b expected 1", ovf2); end
`endif
      tick();
      n_cmp++;
      if (busy2 !== 1'b0) begin n_bad++; $display("FAIL sat_busy_after got %b expected 0", busy2); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_cont();
      test_edges();
      test_reset_mid();
      test_start_while_busy();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation time limit reached, required completion before 3 ms");
      $fatal(1);
   end

endmodule
